// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: one 16-bit carry-lookahead adder reused
// over WORDS cycles, least-significant slice first, with the carry registered between slices.

module CLA16bits (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic [16:0] carry_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Two-level lookahead: 4-bit groups, then a lookahead unit across the groups.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = &p[B +: 4];

            assign carry_o[B]   = grp_c[gi];
            assign carry_o[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign carry_o[B+2] = g[B+1]
                                | (p[B+1] & g[B])
                                | (p[B+1] & p[B] & grp_c[gi]);
            assign carry_o[B+3] = g[B+2]
                                | (p[B+2] & g[B+1])
                                | (p[B+2] & p[B+1] & g[B])
                                | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
        end
    endgenerate

    assign grp_c[0] = cin_i;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & cin_i);
    assign grp_c[2] = grp_g[1]
                    | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & cin_i);
    assign grp_c[3] = grp_g[2]
                    | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
    assign grp_c[4] = grp_g[3]
                    | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_i);

    assign carry_o[16] = grp_c[4];
    assign sum_o       = p ^ carry_o[15:0];
endmodule

module cla_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  sub_i,
    input  logic [16*WORDS-1:0]   a_i,
    input  logic [16*WORDS-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [16*WORDS-1:0]   result_o,
    output logic                  cout_o,
    output logic                  ovf_o
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [WORDS-1:0][15:0]    a_q, a_d;
    logic [WORDS-1:0][15:0]    b_q, b_d;
    logic [WORDS-1:0][15:0]    res_q, res_d;
    logic                      sub_q, sub_d;
    logic                      carry_q, carry_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;

    logic [15:0]               add_a;
    logic [15:0]               add_b;
    logic [15:0]               add_sum;
    logic [16:0]               add_carry;

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q] ^ {16{sub_q}};

    CLA16bits u_cla (
        .a_i     (add_a),
        .b_i     (add_b),
        .cin_i   (carry_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_i;
                    idx_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                    carry_d = sub_i;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q] = add_sum;
                carry_d      = add_carry[16];
                idx_d        = idx_q + 1'b1;
                if (idx_q == IW'(WORDS - 1)) begin
                    idx_d   = '0;
                    cout_d  = add_carry[16];
                    ovf_d   = add_carry[16] ^ add_carry[15];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = res_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Scoreboard bench for cla_mp_sequencer with WORDS=4: expectations are queued at
// stimulus time and checked against each done pulse.

module tb_cla_mp_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         sub_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         cout_o;
    logic         ovf_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic busy_prev = 1'b0;
    logic mon_en = 1'b0;
    exp_t exp_q[$];

    cla_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .sub_i    (sub_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        logic [W:0]  full;
        if (sub) full = {1'b0, a} + {1'b0, ~b} + 1'b1;
        else     full = {1'b0, a} + {1'b0, b};
        e.res  = full[W-1:0];
        e.cout = full[W];
        if (sub) e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        else     e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: latency, scoreboard pop and spurious-done detection.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (busy_o && !busy_prev) accept_cyc = cyc;
            busy_prev = busy_o;
            if (exp_q.size() == 0) begin
                check("spurious_done", {{(W-1){1'b0}}, done_o}, '0);
            end else if (done_o) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("op done at cycle %0d: result=%h cout=%b ovf=%b", cyc, result_o, cout_o, ovf_o);
                check("latency", W'(cyc - accept_cyc), W'(4));
                check("result", result_o, e.res);
                check("cout", {{(W-1){1'b0}}, cout_o}, {{(W-1){1'b0}}, e.cout});
                check("ovf", {{(W-1){1'b0}}, ovf_o}, {{(W-1){1'b0}}, e.ovf});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, {{(W-1){1'b0}}, busy_o}, '0);
        check({tag, "_done"}, {{(W-1){1'b0}}, done_o}, '0);
        check({tag, "_result"}, result_o, '0);
        check({tag, "_cout"}, {{(W-1){1'b0}}, cout_o}, '0);
        check({tag, "_ovf"}, {{(W-1){1'b0}}, ovf_o}, '0);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!done_o && n < 20);
        check("done_seen", {{(W-1){1'b0}}, done_o}, {{(W-1){1'b0}}, 1'b1});
        @(negedge clk_i);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        a_i     = a;
        b_i     = b;
        sub_i   = sub;
        start_i = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(negedge clk_i);
        start_i = 1'b0;
        a_i     = ~a;
        b_i     = ~b;
        sub_i   = ~sub;
        wait_done();
    endtask

    initial begin
        int acc;
        int acc_cyc [2];
        logic mb_prev;

        // Reset held for two cycles with start asserted.
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        mon_en = 1'b1;
        check_zero_outputs("reset1");
        @(negedge clk_i);
        check_zero_outputs("reset2");
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        check("idle_after_reset", {{(W-1){1'b0}}, busy_o}, '0);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(64'h0, 64'h1, 1'b1);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1);

        // Extra start pulses during RUN and DONE must be ignored.
        a_i = 64'h0001_0002_0003_0004;
        b_i = 64'h0010_0020_0030_0040;
        sub_i = 1'b0;
        start_i = 1'b1;
        exp_q.push_back(model(a_i, b_i, 1'b0));
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        a_i = 64'hDEAD_BEEF_0000_1111;
        b_i = 64'h1234_5678_9ABC_DEF0;
        sub_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        begin
            int n = 0;
            while (!done_o && n < 20) begin
                @(negedge clk_i);
                n++;
            end
        end
        check("hs_done_seen", {{(W-1){1'b0}}, done_o}, {{(W-1){1'b0}}, 1'b1});
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("ignored_start", {{(W-1){1'b0}}, busy_o}, '0);

        // start held high: second acceptance must come 6 edges after the first.
        acc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        mb_prev = busy_o;
        a_i = 64'h1111_2222_3333_4444;
        b_i = 64'h5555_6666_7777_8888;
        sub_i = 1'b0;
        start_i = 1'b1;
        exp_q.push_back(model(a_i, b_i, 1'b0));
        for (int n = 0; n < 30 && acc < 2; n++) begin
            @(negedge clk_i);
            if (busy_o && !mb_prev) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 1) begin
                    a_i = 64'h0123_4567_89AB_CDEF;
                    b_i = 64'hFEDC_BA98_7654_3210;
                    sub_i = 1'b1;
                    exp_q.push_back(model(a_i, b_i, 1'b1));
                end else begin
                    start_i = 1'b0;
                end
            end
            mb_prev = busy_o;
        end
        start_i = 1'b0;
        check("accept_spacing", W'(acc_cyc[1] - acc_cyc[0]), W'(6));
        wait_done();

        // Reset after E2 of an add aborts it without a done pulse.
        a_i = 64'h0000_1234_0000_5678;
        b_i = 64'h0000_1111_0000_2222;
        sub_i = 1'b0;
        start_i = 1'b1;
        exp_q.push_back(model(a_i, b_i, 1'b0));
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        void'(exp_q.pop_back());
        check_zero_outputs("abort");
        repeat (3) @(negedge clk_i);
        check("abort_no_done", {{(W-1){1'b0}}, busy_o}, '0);
        run_op(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        check("pending_ops", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
